// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one variable-latency memory port between data access and instruction fetch
module rv32i_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        imem_req_i,
    input  logic [31:0] imem_add_i,
    output logic [31:0] imem_data_o,
    input  logic        dmem_re_i,
    input  logic        dmem_we_i,
    input  logic [31:0] dmem_add_i,
    input  logic [31:0] dmem_di_i,
    input  logic [3:0]  dmem_ble_i,
    output logic [31:0] dmem_do_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_add_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_ble_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, DATA, FETCH, RELEASE} state_t;
    localparam logic [7:0]  TMO = 8'(TIMEOUT);
    localparam logic [31:0] NOP = 32'h0000_0013;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] imem_data_q, imem_data_d, dmem_do_q, dmem_do_d;
    logic        err_q, err_d;
    logic        need_d, need_i, busy, tmo, done;
    assign need_d = dmem_re_i | dmem_we_i;
    assign need_i = imem_req_i;
    assign imem_data_o = imem_data_q;
    assign dmem_do_o = dmem_do_q;
    assign err_o = err_q;
    // next state, memory-side drive, result capture and timeout tracking
    always_comb begin
        state_d = state_q;
        imem_data_d = imem_data_q;
        dmem_do_d = dmem_do_q;
        stall_o = 1'b0;
        mem_req_o = 1'b0;
        mem_we_o = 1'b0;
        mem_add_o = 32'h0;
        mem_wdata_o = 32'h0;
        mem_ble_o = 4'h0;
        busy = (state_q == DATA) || (state_q == FETCH);
        tmo = busy && !mem_ack_i && (cnt_q == TMO);
        done = busy && (mem_ack_i || tmo);
        cnt_d = (busy && !done) ? cnt_q + 8'd1 : 8'd0;
        err_d = err_q | tmo;
        unique case (state_q)
            IDLE: begin
                stall_o = need_d | need_i;
                state_d = need_d ? DATA : need_i ? FETCH : IDLE;
            end
            DATA: begin
                stall_o = 1'b1;
                mem_req_o = 1'b1;
                mem_we_o = dmem_we_i;
                mem_add_o = dmem_add_i;
                mem_wdata_o = dmem_di_i;
                mem_ble_o = dmem_ble_i;
                if (done) begin
                    dmem_do_d = dmem_we_i ? dmem_do_q : mem_ack_i ? mem_rdata_i : 32'h0;
                    state_d = need_i ? FETCH : RELEASE;
                end
            end
            FETCH: begin
                stall_o = 1'b1;
                mem_req_o = 1'b1;
                mem_add_o = imem_add_i;
                mem_ble_o = 4'hF;
                if (done) begin
                    imem_data_d = mem_ack_i ? mem_rdata_i : NOP;
                    state_d = RELEASE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state and result registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            cnt_q <= 8'd0;
            imem_data_q <= NOP;
            dmem_do_q <= 32'h0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            imem_data_q <= imem_data_d;
            dmem_do_q <= dmem_do_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: table-driven cycle-by-cycle check of the memory arbiter
module tb_rv32i_mem_arbiter;
    localparam logic H = 1'b1, L = 1'b0;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk_i, resetn_i, imem_req_i, dmem_re_i, dmem_we_i, mem_ack_i;
    logic [31:0] imem_add_i, dmem_add_i, dmem_di_i, mem_rdata_i;
    logic [3:0]  dmem_ble_i;
    logic [31:0] imem_data_o, dmem_do_o, mem_add_o, mem_wdata_o;
    logic        stall_o, mem_req_o, mem_we_o, err_o;
    logic [3:0]  mem_ble_o;
    int nvec = 0, nbad = 0;

    typedef struct {
        logic        rn, ireq, dre, dwe, ack;
        logic [31:0] iadd, dadd, ddi, rdata;
        logic [3:0]  ble;
        logic [135:0] e;
    } vec_t;

    vec_t tbl[$];

    rv32i_mem_arbiter #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .imem_req_i(imem_req_i), .imem_add_i(imem_add_i), .imem_data_o(imem_data_o),
        .dmem_re_i(dmem_re_i), .dmem_we_i(dmem_we_i), .dmem_add_i(dmem_add_i),
        .dmem_di_i(dmem_di_i), .dmem_ble_i(dmem_ble_i), .dmem_do_o(dmem_do_o),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_add_o(mem_add_o), .mem_wdata_o(mem_wdata_o), .mem_ble_o(mem_ble_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(
        input logic rn, ireq, input logic [31:0] iadd, input logic dre, dwe,
        input logic [31:0] dadd, ddi, input logic [3:0] ble, input logic ack, input logic [31:0] rdata,
        input logic es, er, ew, input logic [31:0] ea, ewd, input logic [3:0] eb,
        input logic [31:0] eid, edo, input logic ee);
        vec_t v;
        v.rn = rn; v.ireq = ireq; v.iadd = iadd; v.dre = dre; v.dwe = dwe;
        v.dadd = dadd; v.ddi = ddi; v.ble = ble; v.ack = ack; v.rdata = rdata;
        v.e = {es, er, ew, ea, ewd, eb, eid, edo, ee};
        return v;
    endfunction

    // drive at the falling edge, compare 2 time units later, then let the rising edge pass
    task automatic apply(input vec_t v, input string tag);
        logic [135:0] act;
        resetn_i = v.rn; imem_req_i = v.ireq; imem_add_i = v.iadd;
        dmem_re_i = v.dre; dmem_we_i = v.dwe; dmem_add_i = v.dadd;
        dmem_di_i = v.ddi; dmem_ble_i = v.ble; mem_ack_i = v.ack; mem_rdata_i = v.rdata;
        #2;
        act = {stall_o, mem_req_o, mem_we_o, mem_add_o, mem_wdata_o, mem_ble_o,
               imem_data_o, dmem_do_o, err_o};
        nvec++;
        if (act !== v.e) begin
            nbad++;
            $display("FAIL %s #%0d: got stall/req/we/add/wd/ble/idata/ddo/err=%h want %h",
                     tag, nvec, act, v.e);
        end
        @(negedge clk_i);
    endtask

    initial begin
        resetn_i = 1'b0; imem_req_i = 1'b0; imem_add_i = '0; dmem_re_i = 1'b0;
        dmem_we_i = 1'b0; dmem_add_i = '0; dmem_di_i = '0; dmem_ble_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);

        tbl.push_back(mk(L,L,0,L,L,0,0,0,L,0,             L,L,L,0,0,0,NOP,0,L));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(H,H,'h100,L,L,0,0,0,H,'h00500093,
                             i < 2 ? H : L, i == 1 ? H : L, L, i == 1 ? 'h100 : 0, 0, i == 1 ? 'hF : 0,
                             i < 2 ? NOP : 'h00500093, 0, L));
        tbl.push_back(mk(H,H,'h104,H,L,'h2000,0,'hF,L,0,  H,L,L,0,0,0,'h00500093,0,L));
        tbl.push_back(mk(H,H,'h104,H,L,'h2000,0,'hF,L,0,  H,H,L,'h2000,0,'hF,'h00500093,0,L));
        tbl.push_back(mk(H,H,'h104,H,L,'h2000,0,'hF,L,0,  H,H,L,'h2000,0,'hF,'h00500093,0,L));
        tbl.push_back(mk(H,H,'h104,H,L,'h2000,0,'hF,H,'hDEADBEEF, H,H,L,'h2000,0,'hF,'h00500093,0,L));
        tbl.push_back(mk(H,H,'h104,H,L,'h2000,0,'hF,L,0,  H,H,L,'h104,0,'hF,'h00500093,'hDEADBEEF,L));
        tbl.push_back(mk(H,H,'h104,H,L,'h2000,0,'hF,L,0,  H,H,L,'h104,0,'hF,'h00500093,'hDEADBEEF,L));
        tbl.push_back(mk(H,H,'h104,H,L,'h2000,0,'hF,H,NOP, H,H,L,'h104,0,'hF,'h00500093,'hDEADBEEF,L));
        tbl.push_back(mk(H,H,'h104,H,L,'h2000,0,'hF,H,NOP, L,L,L,0,0,0,NOP,'hDEADBEEF,L));
        tbl.push_back(mk(H,H,'h108,H,H,'h3000,'h1234,'h3,H,'hAAAA5555, H,L,L,0,0,0,NOP,'hDEADBEEF,L));
        tbl.push_back(mk(H,H,'h108,H,H,'h3000,'h1234,'h3,H,'hAAAA5555, H,H,H,'h3000,'h1234,'h3,NOP,'hDEADBEEF,L));
        tbl.push_back(mk(H,H,'h108,H,H,'h3000,'h1234,'h3,H,'hAAAA5555, H,H,L,'h108,0,'hF,NOP,'hDEADBEEF,L));
        tbl.push_back(mk(H,H,'h108,H,H,'h3000,'h1234,'h3,H,'hAAAA5555, L,L,L,0,0,0,'hAAAA5555,'hDEADBEEF,L));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(H,L,0,L,L,0,0,0,L,0, L,L,L,0,0,0,'hAAAA5555,'hDEADBEEF,L));
        foreach (tbl[i]) apply(tbl[i], "table");

        apply(mk(H,H,'h10C,L,L,0,0,0,L,0, H,L,L,0,0,0,'hAAAA5555,'hDEADBEEF,L), "tmo_fetch_idle");
        for (int i = 0; i < 5; i++)
            apply(mk(H,H,'h10C,L,L,0,0,0,L,0, H,H,L,'h10C,0,'hF,'hAAAA5555,'hDEADBEEF,L), "tmo_fetch_wait");
        apply(mk(H,L,0,L,L,0,0,0,L,0, L,L,L,0,0,0,NOP,'hDEADBEEF,H), "tmo_fetch_release");
        apply(mk(H,H,'h110,L,L,0,0,0,H,'h00100073, H,L,L,0,0,0,NOP,'hDEADBEEF,H), "err_sticky_idle");
        apply(mk(H,H,'h110,L,L,0,0,0,H,'h00100073, H,H,L,'h110,0,'hF,NOP,'hDEADBEEF,H), "err_sticky_fetch");
        apply(mk(H,L,0,L,L,0,0,0,L,0, L,L,L,0,0,0,'h00100073,'hDEADBEEF,H), "err_sticky_release");
        apply(mk(H,L,0,H,L,'h4000,0,'hF,L,0, H,L,L,0,0,0,'h00100073,'hDEADBEEF,H), "tmo_read_idle");
        for (int i = 0; i < 5; i++)
            apply(mk(H,L,0,H,L,'h4000,0,'hF,L,0, H,H,L,'h4000,0,'hF,'h00100073,'hDEADBEEF,H), "tmo_read_wait");
        apply(mk(H,L,0,L,L,0,0,0,L,0, L,L,L,0,0,0,'h00100073,0,H), "tmo_read_release");

        apply(mk(H,L,0,H,L,'h5000,0,'hF,H,'h12345678, H,L,L,0,0,0,'h00100073,0,H), "rst_load_idle");
        apply(mk(H,L,0,H,L,'h5000,0,'hF,H,'h12345678, H,H,L,'h5000,0,'hF,'h00100073,0,H), "rst_load_data");
        apply(mk(H,L,0,L,L,0,0,0,L,0, L,L,L,0,0,0,'h00100073,'h12345678,H), "rst_load_release");
        apply(mk(H,L,0,H,L,'h6000,0,'hF,L,0, H,L,L,0,0,0,'h00100073,'h12345678,H), "rst_wait_idle");
        apply(mk(H,L,0,H,L,'h6000,0,'hF,L,0, H,H,L,'h6000,0,'hF,'h00100073,'h12345678,H), "rst_wait_data");
        apply(mk(L,L,0,H,L,'h6000,0,'hF,H,'hFFFFFFFF, H,H,L,'h6000,0,'hF,'h00100073,'h12345678,H), "rst_assert");
        apply(mk(H,L,0,L,L,0,0,0,H,'hFFFFFFFF, L,L,L,0,0,0,NOP,0,L), "rst_after");
        apply(mk(H,L,0,L,L,0,0,0,H,'hFFFFFFFF, L,L,L,0,0,0,NOP,0,L), "rst_stray_ack");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Sequencer that shares one single-port, variable-latency memory between the pipeline's instruction-fetch port and data-access port. Each core cycle it serves at most one data access and one fetch, in that order. It holds the core in stall until both are done, and captures the read results into registers. It sits between the RV32i top-level core memory ports and the external memory, and drives the core's stall input.

## Interface
- TIMEOUT, default 255: cycles without `mem_ack_i` before a transaction is force-completed; legal range 1..255.
- clk_i  input  1  clock; all state updates on the rising edge.
- resetn_i  input  1  synchronous, active-low reset.
- imem_req_i  input  1  core requests an instruction fetch this core cycle.
- imem_add_i  input  32  fetch address.
- imem_data_o  output  32  registered fetched instruction.
- dmem_re_i  input  1  data read request.
- dmem_we_i  input  1  data write request; if asserted with `dmem_re_i`, the write wins.
- dmem_add_i  input  32  data address.
- dmem_di_i  input  32  write data.
- dmem_ble_i  input  4  byte lane enables for the data access.
- dmem_do_o  output  32  registered data read result.
- stall_o  output  1  core must hold all request inputs stable and not advance.
- mem_req_o  output  1  memory request valid.
- mem_we_o  output  1  memory write.
- mem_add_o  output  32  memory address.
- mem_wdata_o  output  32  memory write data.
- mem_ble_o  output  4  memory byte enables.
- mem_ack_i  input  1  memory completes the current request; may be asserted in the same cycle as `mem_req_o`.
- mem_rdata_i  input  32  read data, valid when `mem_ack_i` is high.
- err_o  output  1  sticky timeout flag.

## Operation
- Request flags: need_d = `dmem_re_i` | `dmem_we_i`; need_i = `imem_req_i`. Both are evaluated from live inputs, which the core holds stable while `stall_o` is high.
- State IDLE:
  - `mem_req_o` = 0.
  - `stall_o` = need_d | need_i.
  - Next state is DATA if need_d, else FETCH if need_i, else IDLE.
- State DATA:
  - `mem_req_o` = 1, `mem_we_o` = `dmem_we_i`, `mem_add_o` = `dmem_add_i`, `mem_wdata_o` = `dmem_di_i`, `mem_ble_o` = `dmem_ble_i`.
  - On ack of a read, `dmem_do_o` <= `mem_rdata_i`. On ack of a write, `dmem_do_o` is unchanged.
  - After ack, next state is FETCH if need_i, else RELEASE.
- State FETCH:
  - `mem_req_o` = 1, `mem_we_o` = 0, `mem_add_o` = `imem_add_i`, `mem_ble_o` = 4'hF, `mem_wdata_o` = 0.
  - On ack, `imem_data_o` <= `mem_rdata_i`, then next state is RELEASE.
- State RELEASE:
  - `stall_o` = 0 and `mem_req_o` = 0 for exactly one cycle, so the core advances.
  - Next state is IDLE.
- `stall_o` is 1 in DATA and FETCH.
- Memory-side outputs are driven to 0 when `mem_req_o` = 0.
- Timeout:
  - An 8-bit wait counter clears on entry to DATA or FETCH and increments each cycle without ack.
  - When the counter reaches TIMEOUT with no ack, the transaction is force-completed as if acked:
    - fetch: `imem_data_o` <= 32'h0000_0013 (NOP);
    - data read: `dmem_do_o` <= 0;
    - data write: dropped.
  - On a timeout, `err_o` <= 1 and stays 1 until reset.
- Ack outside DATA/FETCH is ignored.

## Timing
- Reset values (set on the rising edge with `resetn_i` = 0): state IDLE, `imem_data_o` = 32'h0000_0013, `dmem_do_o` = 0, `err_o` = 0, wait counter = 0.
- After reset, `mem_req_o` = 0 and `stall_o` follows the IDLE rule.
- Reset mid-transaction: the next edge returns to IDLE and drops `mem_req_o` in that cycle. A pending ack in the same cycle is ignored and no result register updates.
- Latency with zero-wait memory (ack in the same cycle as req):
  - fetch only: 3 cycles per core cycle (IDLE, FETCH, RELEASE); `stall_o` high for 2 cycles.
  - data + fetch: 4 cycles; `stall_o` high for 3 cycles.
  - no request: 1 cycle, no stall.
- Each memory wait cycle adds one cycle to the state it occurs in.
- `mem_add_o`, `mem_we_o`, `mem_wdata_o` and `mem_ble_o` are stable from request assertion until and including the ack cycle.
- Result registers update on the ack edge and are visible to the core in RELEASE.
- Timeout: force-completion happens on the edge where the counter equals TIMEOUT, i.e. TIMEOUT+1 cycles after state entry with no ack.

## Test plan
- Reset then fetch only, zero-wait memory: `imem_req_i` = 1, `imem_add_i` = 0x100, `mem_rdata_i` = 0x00500093.
  - `mem_add_o` = 0x100 in cycle 2.
  - `stall_o` = 1,1,0.
  - `imem_data_o` = 0x00500093 in RELEASE.
- Load + fetch, ack after 2 wait cycles each: data address 0x2000 returns 0xDEADBEEF, fetch address 0x104 returns 0x00000013.
  - DATA is issued before FETCH.
  - `dmem_do_o` = 0xDEADBEEF.
  - `stall_o` high for 7 cycles.
- Store with `dmem_ble_i` = 4'b0011, `dmem_di_i` = 0x1234:
  - `mem_we_o` = 1, `mem_ble_o` = 4'b0011, `mem_wdata_o` = 0x1234.
  - `dmem_do_o` is unchanged.
  - The following fetch has `mem_we_o` = 0 and `mem_ble_o` = 4'hF.
- No-ack timeout with TIMEOUT = 4 on a fetch:
  - force-completion on the 5th FETCH cycle.
  - `imem_data_o` = 0x13 and `err_o` = 1, which persists through later good transactions until reset.
- Reset asserted during a DATA wait: `mem_req_o` = 0 in the next cycle, `dmem_do_o` = 0, and a stray ack is ignored.
- Idle core (no requests) for 10 cycles: `stall_o` = 0 and `mem_req_o` = 0 throughout, with no state change.
